fb_stream_packer: RTL and testbench

FB_STREAM_PACKER -- requirements
Module: fb_stream_packer

---
 rtl/fb_stream_packer.sv | 127 ++++++++++++
 tb/tb_fb_stream_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_stream_packer.sv
// Framebuffer stream packer: converts RGBA pixels to RGB565 and gathers RATIO
// input beats into one wide output beat, with a tlast-driven early flush.

module fb_px565 #(
    parameter int SUB_PIXEL_WIDTH = 8
) (
    input  logic [4*SUB_PIXEL_WIDTH-1:0] i_px,
    output logic [15:0]                  o_rgb
);
    localparam int SPW = SUB_PIXEL_WIDTH;

    logic w_unused;

    // Truncate each channel to its top bits; alpha is dropped.
    assign o_rgb    = {i_px[4*SPW-1 -: 5], i_px[3*SPW-1 -: 6], i_px[2*SPW-1 -: 5]};
    assign w_unused = ^i_px;
endmodule

module fb_stream_packer #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT = 2,
    parameter int OUT_PIXELS_PER_BEAT       = 4,
    parameter int SUB_PIXEL_WIDTH           = 8
) (
    input  logic                                                aclk,
    input  logic                                                resetn,
    input  logic                                                s_axis_tvalid,
    output logic                                                s_axis_tready,
    input  logic                                                s_axis_tlast,
    input  logic [NUMBER_OF_PIXELS_PER_BEAT*4*SUB_PIXEL_WIDTH-1:0] s_axis_tdata,
    output logic                                                m_axis_tvalid,
    input  logic                                                m_axis_tready,
    output logic                                                m_axis_tlast,
    output logic [OUT_PIXELS_PER_BEAT*16-1:0]                   m_axis_tdata,
    output logic [OUT_PIXELS_PER_BEAT*2-1:0]                    m_axis_tkeep,
    output logic                                                frameDone
);
    localparam int IN_PX  = NUMBER_OF_PIXELS_PER_BEAT;
    localparam int OUT_PX = OUT_PIXELS_PER_BEAT;
    localparam int SPW    = SUB_PIXEL_WIDTH;
    localparam int RATIO  = OUT_PX / IN_PX;
    localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    logic [IN_PX-1:0][15:0]  w_conv;
    logic [OUT_PX-1:0][15:0] w_nxt_data;
    logic [OUT_PX-1:0]       w_nxt_keep;
    logic                    w_s_tready;
    logic                    w_accept;
    logic                    w_done;

    logic [SLOT_W-1:0]       r_slot;
    logic [OUT_PX-1:0][15:0] r_acc_data;
    logic [OUT_PX-1:0]       r_acc_keep;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic [OUT_PX-1:0][15:0] r_m_data;
    logic [OUT_PX-1:0]       r_m_keep;
    logic                    r_frame_done;

    genvar g;
    generate
        for (g = 0; g < IN_PX; g++) begin : g_conv
            fb_px565 #(.SUB_PIXEL_WIDTH(SPW)) u_px (
                .i_px  (s_axis_tdata[g*4*SPW +: 4*SPW]),
                .o_rgb (w_conv[g])
            );
        end

        // Output pixel j belongs to slot j/IN_PX and takes input lane j%IN_PX.
        for (g = 0; g < OUT_PX; g++) begin : g_slot
            localparam logic [SLOT_W-1:0] JS = SLOT_W'(g / IN_PX);
            assign w_nxt_data[g] = (r_slot == JS) ? w_conv[g % IN_PX] : r_acc_data[g];
            assign w_nxt_keep[g] = (r_slot == JS) | r_acc_keep[g];
            assign m_axis_tkeep[g*2 +: 2] = {2{r_m_keep[g]}};
        end
    endgenerate

    assign w_s_tready = resetn && (!r_m_tvalid || m_axis_tready);
    assign w_accept   = s_axis_tvalid && w_s_tready;
    assign w_done     = w_accept && ((r_slot == LAST_SLOT) || s_axis_tlast);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_slot     <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_slot     <= '0;
                r_acc_data <= '0;
                r_acc_keep <= '0;
            end else begin
                r_slot     <= r_slot + SLOT_W'(1);
                r_acc_data <= w_nxt_data;
                r_acc_keep <= w_nxt_keep;
            end
        end
    end

    // A completion only happens when the output register is empty or draining,
    // so loading it here never overwrites an unsent beat.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_done) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= s_axis_tlast;
                r_m_data   <= w_nxt_data;
                r_m_keep   <= w_nxt_keep;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            r_frame_done <= r_m_tvalid && m_axis_tready && r_m_tlast;
        end
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_data;
    assign frameDone     = r_frame_done;
endmodule

// File: tb/tb_fb_stream_packer.sv
// Scenario bench for fb_stream_packer: a queue-based scoreboard fed on input
// handshakes and drained on output handshakes.

module tb_fb_stream_packer;
    localparam int IW = 64;
    localparam int OW = 64;
    localparam int KW = 8;
    localparam int EW = OW + KW + 1;

    logic          aclk;
    logic          resetn;
    logic          s_tvalid, s_tready, s_tlast;
    logic [IW-1:0] s_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [OW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          frameDone;

    fb_stream_packer dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .frameDone     (frameDone)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [EW-1:0] sb[$];
    int            ms;
    logic [OW-1:0] md;
    logic [KW-1:0] mk;
    logic          in_hs, out_hs, fd, exp_ok, prev_stall;
    logic [EW-1:0] obs, exp_obs, prev_obs;
    int            stab_viol = 0;

    function automatic logic [15:0] cvt(input logic [31:0] p);
        return {p[31:27], p[23:18], p[15:11]};
    endfunction

    // One clock: drive at the falling edge, observe 1 ns later what the next
    // rising edge will transfer, and advance the reference model.
    task automatic tick(input logic v, input logic [IW-1:0] d, input logic l, input logic rdy);
        @(negedge aclk);
        s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = rdy;
        #1;
        in_hs  = s_tvalid && s_tready;
        out_hs = m_tvalid && m_tready;
        obs    = {m_tdata, m_tkeep, m_tlast};
        fd     = frameDone;
        if (prev_stall && (!m_tvalid || obs !== prev_obs)) stab_viol++;
        prev_stall = m_tvalid && !m_tready;
        prev_obs   = obs;
        exp_ok  = 1'b0;
        exp_obs = '0;
        if (out_hs && sb.size() > 0) begin
            exp_obs = sb.pop_front();
            exp_ok  = 1'b1;
        end
        if (in_hs) begin
            for (int i = 0; i < 2; i++) begin
                md[(ms*2+i)*16 +: 16] = cvt(d[i*32 +: 32]);
                mk[(ms*2+i)*2 +: 2]   = 2'b11;
            end
            if (ms == 1 || l) begin
                sb.push_back({md, mk, l});
                md = '0; mk = '0; ms = 0;
            end else begin
                ms = ms + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        resetn = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
        sb.delete();
        ms = 0; md = '0; mk = '0; prev_stall = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge aclk);
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({m_tvalid, m_tlast, frameDone, s_tready} !== 4'b0)
            $display("FAIL reset_ctrl: got %b exp 0000", {m_tvalid, m_tlast, frameDone, s_tready});
        else n_pass++;
        n_chk++;
        if (m_tkeep !== '0) $display("FAIL reset_keep: got %h exp 00", m_tkeep); else n_pass++;
        n_chk++;
        if (m_tdata !== '0) $display("FAIL reset_data: got %h exp 0", m_tdata); else n_pass++;
        release_reset();
        n_chk++;
        if (s_tready !== 1'b1) $display("FAIL reset_release_tready: got %b exp 1", s_tready); else n_pass++;
    endtask

    task automatic test_basic();
        logic [EW-1:0] want;
        want = {64'h001F_FFFF_07E0_F800, 8'hFF, 1'b1};
        tick(1'b1, 64'h00FF00FF_FF0000FF, 1'b0, 1'b1);
        n_chk++;
        if (in_hs !== 1'b1) $display("FAIL basic_accept0: got %b exp 1", in_hs); else n_pass++;
        tick(1'b1, 64'h0000FFFF_FFFFFFFF, 1'b1, 1'b1);
        n_chk++;
        if ({in_hs, m_tvalid} !== 2'b10) $display("FAIL basic_accept1: got %b exp 10", {in_hs, m_tvalid}); else n_pass++;
        tick(1'b0, '0, 1'b0, 1'b1);
        n_chk++;
        if (!out_hs || obs !== want) $display("FAIL basic_beat: got hs=%b %h exp %h", out_hs, obs, want); else n_pass++;
        tick(1'b0, '0, 1'b0, 1'b1);
        n_chk++;
        if ({fd, m_tvalid} !== 2'b10) $display("FAIL basic_framedone: got %b exp 10", {fd, m_tvalid}); else n_pass++;
        tick(1'b0, '0, 1'b0, 1'b1);
        n_chk++;
        if (fd !== 1'b0) $display("FAIL basic_framedone_pulse: got %b exp 0", fd); else n_pass++;
    endtask

    task automatic test_odd_frame();
        logic [IW-1:0] beats[3];
        logic [KW-1:0] keeps[2];
        logic          lasts[2];
        logic [31:0]   upper;
        int            n_out = 0;
        for (int i = 0; i < 3; i++) beats[i] = {$urandom, $urandom};
        upper = '1;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) tick(1'b1, beats[i], i == 2, 1'b1);
            else       tick(1'b0, '0, 1'b0, 1'b1);
            if (out_hs) begin
                n_chk++;
                if (!exp_ok || obs !== exp_obs) $display("FAIL odd_beat: got %h exp %h", obs, exp_obs); else n_pass++;
                if (n_out < 2) begin
                    keeps[n_out] = m_tkeep; lasts[n_out] = m_tlast;
                    if (n_out == 1) upper = m_tdata[63:32];
                end
                n_out++;
            end
        end
        n_chk++;
        if (n_out != 2) $display("FAIL odd_count: got %0d exp 2", n_out);
        else if ({keeps[0], lasts[0], keeps[1], lasts[1]} !== {8'hFF, 1'b0, 8'h0F, 1'b1})
            $display("FAIL odd_keep_last: got %h/%b %h/%b exp ff/0 0f/1", keeps[0], lasts[0], keeps[1], lasts[1]);
        else if (upper !== 32'h0) $display("FAIL odd_upper: got %h exp 0", upper);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] hold;
        int            n_out = 0;
        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        n_chk++;
        if (in_hs !== 1'b1) $display("FAIL bp_fill: got %b exp 1", in_hs); else n_pass++;
        hold = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0);
            if (i == 0) hold = obs;
            n_chk++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || obs !== hold)
                $display("FAIL bp_stall%0d: got tready=%b tvalid=%b %h exp 0/1 %h", i, s_tready, m_tvalid, obs, hold);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) tick(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1);
            else        tick(1'b0, '0, 1'b0, 1'b1);
            if (out_hs) begin
                n_out++;
                n_chk++;
                if (!exp_ok || obs !== exp_obs) $display("FAIL bp_beat: got %h exp %h", obs, exp_obs); else n_pass++;
            end
        end
        n_chk++;
        if (n_out != 2 || sb.size() != 0) $display("FAIL bp_count: got %0d left %0d exp 2 left 0", n_out, sb.size());
        else n_pass++;
    endtask

    task automatic test_throughput();
        int n_out = 0, n_fd = 0, stalls = 0, last_cyc = -1, bad = 0;
        for (int c = 0; c < 1027; c++) begin
            if (c < 1024) tick(1'b1, {$urandom, $urandom}, (c % 64) == 63, 1'b1);
            else          tick(1'b0, '0, 1'b0, 1'b1);
            if (c < 1024 && !in_hs) stalls++;
            if (fd) n_fd++;
            if (out_hs) begin
                n_out++;
                last_cyc = c;
                n_chk++;
                if (!exp_ok || obs !== exp_obs) begin
                    bad++;
                    if (bad < 5) $display("FAIL tp_beat%0d: got %h exp %h", n_out, obs, exp_obs);
                end else n_pass++;
            end
        end
        n_chk++;
        if (stalls != 0) $display("FAIL tp_stalls: got %0d exp 0", stalls); else n_pass++;
        n_chk++;
        if (n_out != 512 || last_cyc != 1024) $display("FAIL tp_outs: got %0d at %0d exp 512 at 1024", n_out, last_cyc);
        else n_pass++;
        n_chk++;
        if (n_fd != 16) $display("FAIL tp_framedone: got %0d exp 16", n_fd); else n_pass++;
    endtask

    task automatic test_random();
        int            sent = 0, cyc = 0, bad = 0;
        logic          v, l, pend;
        logic [IW-1:0] d;
        v = 1'b0; l = 1'b0; d = '0; pend = 1'b0;
        stab_viol = 0;
        while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
            if (!pend) begin
                v = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                d = {$urandom, $urandom};
                l = ($urandom_range(0, 7) == 0);
            end
            tick(v, d, l, (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b1);
            pend = v && !in_hs;
            if (in_hs) sent++;
            if (out_hs) begin
                n_chk++;
                if (!exp_ok || obs !== exp_obs) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_beat: got %h exp %h", obs, exp_obs);
                end else n_pass++;
            end
            cyc++;
        end
        n_chk++;
        if (sent != 10000 || sb.size() != 0) $display("FAIL rand_done: sent %0d left %0d exp 10000 left 0", sent, sb.size());
        else n_pass++;
        n_chk++;
        if (stab_viol != 0) $display("FAIL rand_stability: got %0d exp 0", stab_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [IW-1:0] dd;
        int            n_out = 0;
        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
        do_reset();
        n_chk++;
        if ({m_tvalid, m_tlast, s_tready, m_tkeep, m_tdata} !== '0)
            $display("FAIL mid_reset_outs: got %b%b%b %h %h exp 0", m_tvalid, m_tlast, s_tready, m_tkeep, m_tdata);
        else n_pass++;
        release_reset();
        dd = {$urandom, $urandom};
        tick(1'b1, dd, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        n_chk++;
        if (!out_hs || obs !== {32'h0, cvt(dd[63:32]), cvt(dd[31:0]), 8'h0F, 1'b1})
            $display("FAIL mid_fresh_beat: got hs=%b %h exp %h", out_hs, obs,
                     {32'h0, cvt(dd[63:32]), cvt(dd[31:0]), 8'h0F, 1'b1});
        else n_pass++;
        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        do_reset();
        release_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b0, 1'b1);
            if (out_hs) n_out++;
        end
        n_chk++;
        if (n_out != 0) $display("FAIL mid_stale_beat: got %0d exp 0", n_out); else n_pass++;
    endtask

    initial begin
        resetn = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
        ms = 0; md = '0; mk = '0; prev_stall = 1'b0; prev_obs = '0;
        test_reset();
        test_basic();
        test_odd_frame();
        test_backpressure();
        test_throughput();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
